// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic sign/magnitude multiplier:
// FSM states, maximal-length LFSR tap masks and default seeds.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] SEED_A_DEF = 8'h01;
  localparam logic [7:0] SEED_B_DEF = 8'hB5;

  // Fibonacci tap masks, bit i set means stage i+1 feeds the XOR
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      8:       return 16'h00B8;  // x^8+x^6+x^5+x^4+1
      12:      return 16'h0829;  // x^12+x^6+x^4+x+1
      16:      return 16'hD008;  // x^16+x^15+x^13+x^4+1
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR with synchronous seed load; shifts toward the MSB and
// feeds the XOR of the tapped stages back into bit 0.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int             W    = 8,
  parameter logic [W-1:0]   TAPS = W'(lfsr_taps(W)),
  parameter logic [W-1:0]   SEED = W'(1)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] state
);

  logic [W-1:0] r_state;
  logic         w_feedback;

  assign w_feedback = ^(r_state & TAPS);

  always_ff @(posedge clock) begin
    if (!resetn || load) begin
      r_state <= SEED;
    end else if (step) begin
      r_state <= {r_state[W-2:0], w_feedback};
    end
  end

  assign state = r_state;

  // A zero seed locks the register at zero forever
  a_never_zero: assert property (@(posedge clock) disable iff (!resetn) r_state != '0);

endmodule

// File: rtl/sc_sm_multiplier.sv
// Stochastic sign/magnitude multiplier: counts AND-ed comparator bits over one
// full LFSR period and re-applies the product sign as two's complement.
module sc_sm_multiplier
  import sc_pkg::*;
#(
  parameter int                 W_MAG  = 8,
  parameter logic [W_MAG-1:0]   SEED_A = W_MAG'(SEED_A_DEF),
  parameter logic [W_MAG-1:0]   SEED_B = W_MAG'(SEED_B_DEF)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_sign,
  input  logic [W_MAG-1:0] a_mag,
  input  logic             b_sign,
  input  logic [W_MAG-1:0] b_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_MAG:0]   out_prod
);

  localparam logic [W_MAG-1:0] TAPS     = W_MAG'(lfsr_taps(W_MAG));
  localparam logic [W_MAG-1:0] CYC_LAST = {{(W_MAG-1){1'b1}}, 1'b0};

  state_t           r_state, w_state_next;
  logic [W_MAG-1:0] r_a_mag, r_b_mag, r_cnt, r_cyc;
  logic             r_sgn;
  logic [W_MAG-1:0] w_lfsr_a, w_lfsr_b;
  logic             w_accept, w_step, w_bit_a, w_bit_b;
  logic [W_MAG:0]   w_mag_ext;

  sc_lfsr #(.W(W_MAG), .TAPS(TAPS), .SEED(SEED_A)) u_lfsr_a (
    .clock  (clock),
    .resetn (resetn),
    .load   (w_accept),
    .step   (w_step),
    .state  (w_lfsr_a)
  );

  sc_lfsr #(.W(W_MAG), .TAPS(TAPS), .SEED(SEED_B)) u_lfsr_b (
    .clock  (clock),
    .resetn (resetn),
    .load   (w_accept),
    .step   (w_step),
    .state  (w_lfsr_b)
  );

  assign w_bit_a = (r_a_mag >= w_lfsr_a);
  assign w_bit_b = (r_b_mag >= w_lfsr_b);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cyc == CYC_LAST) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_a_mag <= '0;
      r_b_mag <= '0;
      r_sgn   <= 1'b0;
      r_cnt   <= '0;
      r_cyc   <= '0;
    end else if (w_accept) begin
      r_a_mag <= a_mag;
      r_b_mag <= b_mag;
      r_sgn   <= a_sign ^ b_sign;
      r_cnt   <= '0;
      r_cyc   <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + {{(W_MAG-1){1'b0}}, (w_bit_a & w_bit_b)};
      r_cyc <= r_cyc + 1'b1;
    end
  end

  // Negating a zero count yields zero, so no negative zero can appear
  assign w_mag_ext = {1'b0, r_cnt};

  always_comb begin
    out_prod = '0;
    if (r_state == ST_DONE) begin
      out_prod = r_sgn ? -w_mag_ext : w_mag_ext;
    end
  end

endmodule

// File: tb/tb_sc_sm_multiplier.sv
// Directed self-checking bench for sc_sm_multiplier (W_MAG=8, default seeds).
module tb_sc_sm_multiplier;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       a_sign = 1'b0;
  logic       b_sign = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a_mag = 8'd0;
  logic [7:0] b_mag = 8'd0;
  logic       in_ready;
  logic       out_valid;
  logic [8:0] out_prod;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int accept_stamp = 0;

  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  sc_sm_multiplier dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_sign    (a_sign),
    .a_mag     (a_mag),
    .b_sign    (b_sign),
    .b_mag     (b_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod)
  );

  // Independent bit-level reference: x^8+x^6+x^5+x^4+1, seeds 01/B5
  function automatic logic [8:0] golden(input logic as, input logic [7:0] am,
                                        input logic bs, input logic [7:0] bm);
    logic [7:0] la;
    logic [7:0] lb;
    logic [8:0] mag;
    int c;
    la = 8'h01;
    lb = 8'hB5;
    c = 0;
    for (int i = 0; i < 255; i++) begin
      if (am >= la && bm >= lb) c++;
      la = {la[6:0], la[7] ^ la[5] ^ la[4] ^ la[3]};
      lb = {lb[6:0], lb[7] ^ lb[5] ^ lb[4] ^ lb[3]};
    end
    mag = 9'(c);
    return (as ^ bs) ? -mag : mag;
  endfunction

  // All tasks start and end at a falling edge
  task automatic start_op(input logic as, input logic [7:0] am, input logic bs, input logic [7:0] bm);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready got %b want 1", in_ready);
    end
    in_valid = 1'b1; a_sign = as; a_mag = am; b_sign = bs; b_mag = bm;
    @(posedge clock);
    @(negedge clock);
    accept_stamp = edge_cnt;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 1000) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL done_timeout got out_valid=%b want 1 within 1000 clocks", out_valid);
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_release got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic do_op(input string name, input logic as, input logic [7:0] am,
                       input logic bs, input logic [7:0] bm, input logic [8:0] exp_prod);
    int n;
    start_op(as, am, bs, bm);
    wait_done(n);
    checks++;
    if (out_prod !== exp_prod) begin
      errors++;
      $display("FAIL %s got %0d (0x%h) want %0d (0x%h)", name,
               $signed(out_prod), out_prod, $signed(exp_prod), exp_prod);
    end
    $display("op %s: a=%s%0d b=%s%0d prod=%0d latency=%0d", name, as ? "-" : "+", am,
             bs ? "-" : "+", bm, $signed(out_prod), n);
    ack();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_prod !== 9'd0) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b prod=%h want 1 0 000",
               in_ready, out_valid, out_prod);
    end
  endtask

  task automatic test_full_scale();
    int n;
    start_op(1'b0, 8'd255, 1'b0, 8'd255);
    wait_done(n);
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL latency got %0d want 256", n);
    end
    checks++;
    if (out_prod !== 9'h0FF) begin
      errors++;
      $display("FAIL full_scale got %h want 0ff", out_prod);
    end
    $display("op full_scale: prod=%0d latency=%0d", $signed(out_prod), n);
    ack();
  endtask

  task automatic test_boundary_mags();
    do_op("pos255_neg100", 1'b0, 8'd255, 1'b1, 8'd100, 9'h19C);
    do_op("negzero_pos77", 1'b1, 8'd0,   1'b0, 8'd77,  9'h000);
    do_op("neg37_negzero", 1'b1, 8'd37,  1'b1, 8'd0,   9'h000);
    do_op("neg200_pos255", 1'b1, 8'd200, 1'b0, 8'd255, 9'h138);
    do_op("neg255_pos1",   1'b1, 8'd255, 1'b0, 8'd1,   9'h1FF);
  endtask

  task automatic test_golden();
    do_op("pos128_pos128", 1'b0, 8'd128, 1'b0, 8'd128, golden(1'b0, 8'd128, 1'b0, 8'd128));
    do_op("neg128_pos200", 1'b1, 8'd128, 1'b0, 8'd200, golden(1'b1, 8'd128, 1'b0, 8'd200));
  endtask

  task automatic test_handshake();
    int n;
    logic [8:0] held;
    logic stable;
    start_op(1'b0, 8'd255, 1'b1, 8'd3);
    // Upstream presents a new pair throughout RUN and DONE
    in_valid = 1'b1; a_sign = 1'b0; a_mag = 8'd255; b_sign = 1'b0; b_mag = 8'd255;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_ready got %b want 0", in_ready);
    end
    wait_done(n);
    held = out_prod;
    checks++;
    if (held !== 9'h1FD) begin
      errors++;
      $display("FAIL stall_value got %h want 1fd", held);
    end
    stable = 1'b1;
    repeat (10) begin
      @(posedge clock);
      @(negedge clock);
      if (out_prod !== held || out_valid !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL stall_hold got valid=%b prod=%h want 1 %h", out_valid, out_prod, held);
    end
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_ignores_input got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    $display("op handshake: prod=%0d held for 10 stalled cycles", $signed(held));
  endtask

  task automatic test_back_to_back();
    int t_first;
    do_op("b2b_pos50", 1'b0, 8'd255, 1'b0, 8'd50, 9'h032);
    t_first = accept_stamp;
    do_op("b2b_negneg10", 1'b1, 8'd255, 1'b1, 8'd10, 9'h00A);
    checks++;
    if (accept_stamp - t_first !== 257) begin
      errors++;
      $display("FAIL throughput got %0d want 257", accept_stamp - t_first);
    end
    do_op("b2b_neg128", 1'b0, 8'd128, 1'b1, 8'd255, 9'h180);
  endtask

  task automatic test_reset_mid_run();
    logic quiet;
    start_op(1'b0, 8'd255, 1'b0, 8'd200);
    repeat (50) begin
      @(posedge clock);
      @(negedge clock);
    end
    resetn = 1'b0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_prod !== 9'd0) begin
      errors++;
      $display("FAIL midrun_reset got valid=%b ready=%b prod=%h want 0 1 000",
               out_valid, in_ready, out_prod);
    end
    quiet = 1'b1;
    repeat (300) begin
      @(posedge clock);
      @(negedge clock);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL abandoned_output got out_valid=1 want 0");
    end
    $display("op midrun_reset: abandoned, ready=%b", in_ready);
    do_op("after_reset", 1'b0, 8'd255, 1'b0, 8'd200, 9'h0C8);
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_full_scale();
    test_boundary_mags();
    test_golden();
    test_handshake();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
